// File: rtl/control_ronda.sv
// Round/match controller: scores round winners, pulses the game-counter reset
// between rounds and latches the match champion until restarted.
module control_ronda #(
    parameter int N_JUG       = 2,
    parameter int PUNTOS_META = 3,
    parameter int W_PTS       = 4,
    parameter int PULSO_RST   = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     reiniciar,
    input  logic                     apagar,
    input  logic [N_JUG-1:0]         ganador,
    output logic                     resetContador,
    output logic [N_JUG*W_PTS-1:0]   puntos,
    output logic [N_JUG-1:0]         campeon,
    output logic                     finPartida
);

    typedef enum logic [1:0] {JUGANDO, PULSO, FIN} estado_e;

    localparam logic [7:0]       CNT_LLENO = 8'(PULSO_RST - 1);
    localparam logic [W_PTS-1:0] META      = W_PTS'(PUNTOS_META);

    estado_e                   estado, estadoSig;
    logic [7:0]                cnt, cntSig;
    logic                      prevApagar;
    logic                      evento;
    logic [N_JUG-1:0]          elegido;
    logic [W_PTS-1:0]          marcador;
    logic [N_JUG*W_PTS-1:0]    puntosSig;
    logic [N_JUG-1:0]          campeonSig;
    logic                      finSig;
    logic                      resetContadorSig;

    assign evento  = apagar & ~prevApagar;
    // Isolates the lowest-index set ganador bit, so ties go to the lowest player.
    assign elegido = ganador & (-ganador);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        estadoSig  = estado;
        cntSig     = cnt;
        puntosSig  = puntos;
        campeonSig = campeon;
        finSig     = finPartida;
        marcador   = '0;

        if (reiniciar) begin
            estadoSig  = PULSO;
            cntSig     = CNT_LLENO;
            puntosSig  = '0;
            campeonSig = '0;
            finSig     = 1'b0;
        end else begin
            unique case (estado)
                JUGANDO: begin
                    if (evento) begin
                        estadoSig = PULSO;
                        cntSig    = CNT_LLENO;
                        for (int i = 0; i < N_JUG; i++) begin
                            if (elegido[i]) begin
                                marcador = puntos[i*W_PTS +: W_PTS];
                                if (marcador < META) begin
                                    marcador = marcador + W_PTS'(1);
                                    puntosSig[i*W_PTS +: W_PTS] = marcador;
                                    if (marcador == META) begin
                                        campeonSig = elegido;
                                        finSig     = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                PULSO: begin
                    if (cnt == 8'd0) estadoSig = finPartida ? FIN : JUGANDO;
                    else             cntSig    = cnt - 8'd1;
                end
                FIN:     ;
                default: estadoSig = PULSO;
            endcase
        end

        // Registered copy of "not playing": high through every PULSO and FIN cycle.
        resetContadorSig = (estadoSig != JUGANDO);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            estado        <= PULSO;
            cnt           <= CNT_LLENO;
            resetContador <= 1'b1;
            puntos        <= '0;
            campeon       <= '0;
            finPartida    <= 1'b0;
            prevApagar    <= 1'b1;
        end else begin
            estado        <= estadoSig;
            cnt           <= cntSig;
            resetContador <= resetContadorSig;
            puntos        <= puntosSig;
            campeon       <= campeonSig;
            finPartida    <= finSig;
            prevApagar    <= apagar;
        end
    end

endmodule

// File: tb/tb_control_ronda.sv
// Directed self-checking bench for control_ronda: default configuration plus
// a 4-player, 1-point instance for the lowest-index tie-break.
module tb_control_ronda;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reiniciar;
    logic        apagar;
    logic [1:0]  ganador;
    logic        resetContador;
    logic [7:0]  puntos;
    logic [1:0]  campeon;
    logic        finPartida;

    logic        apagarB;
    logic [3:0]  ganadorB;
    logic        resetContadorB;
    logic [15:0] puntosB;
    logic [3:0]  campeonB;
    logic        finPartidaB;

    int nChecks = 0;
    int nFails  = 0;
    int n;

    always #5 clk = ~clk;

    control_ronda dut (
        .clk(clk), .resetN(resetN), .reiniciar(reiniciar), .apagar(apagar),
        .ganador(ganador), .resetContador(resetContador), .puntos(puntos),
        .campeon(campeon), .finPartida(finPartida)
    );

    control_ronda #(.N_JUG(4), .PUNTOS_META(1)) dutB (
        .clk(clk), .resetN(resetN), .reiniciar(reiniciar), .apagar(apagarB),
        .ganador(ganadorB), .resetContador(resetContadorB), .puntos(puntosB),
        .campeon(campeonB), .finPartida(finPartidaB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts clock cycles until resetContador drops; bounded so a stuck pulse still ends.
    task automatic contarPulso(output int cuenta);
        cuenta = 0;
        while (resetContador && cuenta < 40) begin
            @(negedge clk);
            cuenta++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the event edge.
    task automatic evento(input logic [1:0] g);
        ganador = g;
        apagar  = 1'b1;
        @(negedge clk);
        apagar  = 1'b0;
    endtask

    initial begin
        resetN = 1'b1; reiniciar = 1'b0; apagar = 1'b0; ganador = 2'b00;
        apagarB = 1'b0; ganadorB = 4'b0000;
        #1 resetN = 1'b0;
        #1;
        check("rst_rc",  resetContador, 1);
        check("rst_pts", puntos, 8'h00);
        check("rst_cam", campeon, 2'b00);
        check("rst_fin", finPartida, 0);

        // Reset release: 4-cycle pulse then play.
        @(negedge clk) resetN = 1'b1;
        contarPulso(n);
        check("rst_pulse_len", n, 4);
        check("play_rc", resetContador, 0);
        check("play_pts", puntos, 8'h00);

        // 4-player instance: tie between players 2 and 3 goes to player 2.
        ganadorB = 4'b1100; apagarB = 1'b1;
        @(negedge clk) apagarB = 1'b0;
        check("b_campeon", campeonB, 4'b0100);
        check("b_fin", finPartidaB, 1);
        check("b_puntos", puntosB, 16'h0100);

        // Tie in the default instance: only player 0 scores.
        evento(2'b11);
        check("tie_pts", puntos, 8'h01);
        check("tie_rc", resetContador, 1);
        contarPulso(n);
        check("tie_pulse_len", n, 4);

        // apagar held high for 10 cycles: a single increment.
        ganador = 2'b01; apagar = 1'b1;
        repeat (10) @(negedge clk);
        apagar = 1'b0;
        check("hold_pts", puntos, 8'h02);
        check("hold_rc", resetContador, 0);

        // Event with no winner only pulses; an event inside the pulse is ignored.
        @(negedge clk);
        evento(2'b00);
        check("nowin_pts", puntos, 8'h02);
        check("nowin_rc", resetContador, 1);
        @(negedge clk);
        evento(2'b01);
        check("inpulse_pts", puntos, 8'h02);
        contarPulso(n);
        check("inpulse_norestart", n, 2);

        // Player 1 wins three rounds.
        evento(2'b10);
        check("p1_first", puntos, 8'h12);
        contarPulso(n);
        evento(2'b10);
        check("p1_second", puntos, 8'h22);
        check("p1_second_fin", finPartida, 0);
        contarPulso(n);
        evento(2'b10);
        check("p1_third", puntos, 8'h32);
        check("p1_campeon", campeon, 2'b10);
        check("p1_fin", finPartida, 1);
        repeat (8) @(negedge clk);
        check("fin_rc", resetContador, 1);
        check("fin_pts", puntos, 8'h32);
        evento(2'b01);
        @(negedge clk);
        check("fin_ignore_pts", puntos, 8'h32);
        check("fin_ignore_cam", campeon, 2'b10);
        check("fin_ignore_rc", resetContador, 1);

        // Restart in FIN together with an apagar event, held for 3 cycles.
        reiniciar = 1'b1; ganador = 2'b01; apagar = 1'b1;
        @(negedge clk);
        check("rein_pts", puntos, 8'h00);
        check("rein_cam", campeon, 2'b00);
        check("rein_fin", finPartida, 0);
        check("rein_rc", resetContador, 1);
        repeat (2) @(negedge clk);
        reiniciar = 1'b0; apagar = 1'b0;
        contarPulso(n);
        check("rein_pulse_len", n, 4);
        check("rein_after_pts", puntos, 8'h00);

        // Asynchronous reset in the middle of a pulse, apagar held through it.
        evento(2'b01);
        check("pre_rst_pts", puntos, 8'h01);
        apagar = 1'b1;
        #2 resetN = 1'b0;
        #1;
        check("async_pts", puntos, 8'h00);
        check("async_rc", resetContador, 1);
        @(negedge clk) resetN = 1'b1;
        contarPulso(n);
        check("async_pulse_len", n, 4);
        repeat (3) @(negedge clk);
        check("held_apagar_pts", puntos, 8'h00);
        apagar = 1'b0;
        @(negedge clk);
        evento(2'b01);
        check("alive_pts", puntos, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/control_ronda.md
CONTROL_RONDA -- requirements
Module: control_ronda

Interface
REQ-001 Parameter N_JUG, default 2: number of players, legal 2..8.
REQ-002 Parameter PUNTOS_META, default 3: round wins needed to win the match, legal 1..(2^W_PTS)-1.
REQ-003 Parameter W_PTS, default 4: width of each player score field.
REQ-004 Parameter PULSO_RST, default 4: length in cycles of each resetContador pulse, legal 1..255.
REQ-005 clk  input  1  the single clock; all state changes on rising edge.
REQ-006 resetN  input  1  reset, asynchronous, active-low.
REQ-007 reiniciar  input  1  synchronous match restart, active-high level.
REQ-008 apagar  input  1  round-end signal; only its rising edge is an event.
REQ-009 ganador  input  N_JUG  per-player round-winner flags, sampled on the apagar event.
REQ-010 resetContador  output  1  registered reset to the game counter, active-high.
REQ-011 puntos  output  N_JUG*W_PTS  registered scores; player i in bits [i*W_PTS +: W_PTS].
REQ-012 campeon  output  N_JUG  registered one-hot match winner; all-zero while no winner.
REQ-013 finPartida  output  1  registered; high while the match is over.

Function
REQ-014 The FSM SHALL have exactly three states: JUGANDO, PULSO, FIN.
REQ-015 An apagar event SHALL be a cycle where apagar=1 and the registered previous apagar=0; the previous-apagar register SHALL update in every state.
REQ-016 In JUGANDO, an apagar event with ganador=0 SHALL only enter PULSO; no score changes.
REQ-017 In JUGANDO, an apagar event with ganador!=0 SHALL add 1 to the score of the lowest-index set ganador bit only, then enter PULSO.
REQ-018 If that increment makes the score equal PUNTOS_META, campeon SHALL be set one-hot to that player and finPartida SHALL be set at the same edge.
REQ-019 Scores SHALL saturate at PUNTOS_META; no wrap-around.
REQ-020 Entering PULSO SHALL load a down-counter with PULSO_RST-1; resetContador SHALL be 1 in every PULSO cycle, exactly PULSO_RST cycles in total.
REQ-021 PULSO with counter=0 SHALL go to FIN if finPartida=1, otherwise to JUGANDO.
REQ-022 apagar events during PULSO or FIN SHALL be ignored: no score change and no pulse restart.
REQ-023 In FIN, resetContador SHALL stay 1, and puntos, campeon and finPartida SHALL hold.
REQ-024 reiniciar=1 in any state SHALL clear puntos, campeon and finPartida and enter PULSO with a full count.
REQ-025 reiniciar SHALL take priority over a simultaneous apagar event; that event is discarded.
REQ-026 reiniciar held high SHALL keep reloading the count, so resetContador stays 1 until PULSO_RST cycles after its release.
REQ-027 In JUGANDO, resetContador SHALL be 0.

Reset
REQ-028 resetN=0 SHALL immediately and asynchronously set state=PULSO, count=PULSO_RST-1, resetContador=1, puntos=0, campeon=0, finPartida=0, previous-apagar=1.
REQ-029 After resetN deasserts, resetContador SHALL remain 1 for PULSO_RST cycles, then the FSM enters JUGANDO.
REQ-030 previous-apagar reset to 1 SHALL prevent apagar held high through reset from creating an event.
REQ-031 resetN asserted mid-PULSO or in FIN SHALL abort the operation; the reset values of REQ-028 apply.

Verification
REQ-032 Defaults. Release resetN; hold apagar=0.
  -> resetContador=1 for exactly 4 cycles, then 0; puntos=0.
REQ-033 Defaults, in JUGANDO. Drive ganador=2'b11 with one apagar rising edge.
  -> puntos[3:0]=1, puntos[7:4]=0; resetContador=1 for 4 cycles.
REQ-034 Defaults. Give player 1 three scored events.
  -> On the third: puntos[7:4]=3, campeon=2'b10, finPartida=1.
  -> After the 4-cycle pulse: FIN, with resetContador held at 1.
  -> Further apagar edges: no change.
REQ-035 Defaults. Assert reiniciar in FIN in the same cycle as an apagar event.
  -> Scores, campeon and finPartida clear; the event is ignored.
  -> resetContador stays 1 for 4 cycles after reiniciar drops, then JUGANDO.
REQ-036 Defaults. Hold apagar high for 10 cycles in JUGANDO with ganador=2'b01.
  -> Exactly one increment.
REQ-037 Defaults. Assert resetN mid-PULSO.
  -> Outputs take reset values asynchronously, before the next clock edge.
REQ-038 N_JUG=4, PUNTOS_META=1. Drive ganador=4'b1100 with an apagar event.
  -> campeon=4'b0100.
